// File: rtl/drop_animator.sv
// Tick-driven Connect-4 chip drop animator: walks a chip from row 0 to its landing
// row one row per divider tick, holds it there briefly, then pulses done.
module drop_animator #(
  parameter int unsigned ROWS       = 6,
  parameter int unsigned COLS       = 7,
  parameter int unsigned HOLD_TICKS = 2,
  parameter logic [1:0]  FALL_SPEED = 2'b10,
  parameter logic [1:0]  HOLD_SPEED = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] col,
  input  logic [2:0] land_row,
  input  logic       cancel,
  input  logic       tick,
  output logic [1:0] speed,
  output logic       busy,
  output logic       chip_vis,
  output logic [2:0] cur_row,
  output logic [2:0] cur_col,
  output logic       done,
  output logic       err
);

  localparam int unsigned HW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HW:0] HOLD_LAST = (HW + 1)'(HOLD_TICKS);
  localparam logic [3:0]  ROWS_L    = 4'(ROWS);
  localparam logic [3:0]  COLS_L    = 4'(COLS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_FALL = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]    state, state_n;
  logic [2:0]    land_q, land_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [HW:0]   hold_inc;
  logic [2:0]    cur_row_n, cur_col_n;
  logic [1:0]    speed_n;
  logic          busy_n, chip_vis_n, done_n, err_n;
  logic          args_ok;

  assign args_ok  = ({1'b0, col} < COLS_L) && ({1'b0, land_row} < ROWS_L);
  assign hold_inc = {1'b0, hold_cnt} + (HW + 1)'(1);

  // State and all outputs registered together; outputs are a decode of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      land_q   <= 3'd0;
      hold_cnt <= '0;
      cur_row  <= 3'd0;
      cur_col  <= 3'd0;
      speed    <= 2'b00;
      busy     <= 1'b0;
      chip_vis <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      land_q   <= land_n;
      hold_cnt <= hold_n;
      cur_row  <= cur_row_n;
      cur_col  <= cur_col_n;
      speed    <= speed_n;
      busy     <= busy_n;
      chip_vis <= chip_vis_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    land_n    = land_q;
    hold_n    = hold_cnt;
    cur_row_n = cur_row;
    cur_col_n = cur_col;
    err_n     = 1'b0;

    if (cancel && (state != S_IDLE)) begin
      state_n   = S_IDLE;
      land_n    = 3'd0;
      hold_n    = '0;
      cur_row_n = 3'd0;
      cur_col_n = 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // cancel still outranks start here, even though it aborts nothing
          if (start && !cancel) begin
            if (args_ok) begin
              state_n   = S_ARM;
              land_n    = land_row;
              cur_col_n = col;
              cur_row_n = 3'd0;
              hold_n    = '0;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        S_ARM: begin
          if (tick) begin
            hold_n  = '0;
            state_n = (land_q == 3'd0) ? S_HOLD : S_FALL;
          end
        end
        S_FALL: begin
          if (tick) begin
            if (cur_row == land_q) begin
              state_n = S_HOLD;
              hold_n  = '0;
            end else begin
              cur_row_n = cur_row + 3'd1;
            end
          end
        end
        S_HOLD: begin
          if (HOLD_TICKS == 0) begin
            state_n = S_FIN;
          end else if (tick) begin
            hold_n = hold_inc[HW-1:0];
            if (hold_inc == HOLD_LAST) state_n = S_FIN;
          end
        end
        S_FIN:   state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    busy_n     = (state_n == S_ARM) || (state_n == S_FALL) || (state_n == S_HOLD);
    chip_vis_n = busy_n;
    done_n     = (state_n == S_FIN);
    if (state_n == S_FALL)     speed_n = FALL_SPEED;
    else if (busy_n)           speed_n = HOLD_SPEED;
    else                       speed_n = 2'b00;
  end

endmodule
